muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide execution unit, parametrised in operand width, that sits beside the ALU in the EX stage of the pipelined core. It accepts one operation while the instruction is held in EX and computes it over XLEN cycles with shift-add multiplication or restoring division. It raises a stall request that the hazard unit turns into bubbles on the F/D/E/M stages until the result is ready. Divide-by-zero and signed overflow are handled per the RISC-V M specification on a 1-cycle fast path.

## Interface
- XLEN, 32, operand and result width; any even value ≥ 8. Counter width is derived as clog2(XLEN)+1.
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  aborts the operation in flight; driven by flushE.
- op_valid  in  1  a M-extension instruction occupies EX; held high while the stall lasts.
- funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op1  in  XLEN  rs1 value after forwarding.
- op2  in  XLEN  rs2 value after forwarding.
- stall_req  out  1  combinational: op_valid & ~done.
- done  out  1  registered; high for exactly one cycle when result is valid.
- result  out  XLEN  registered result; holds its last value until the next completion.
- busy  out  1  high when state ≠ IDLE.

## Operation
- States are IDLE, BUSY and DONE.
- **IDLE:**
  - With op_valid & ~flush, latch funct3, the operand signs and the magnitudes.
  - Signed operands are used for MUL, MULH, MULHSU op1, DIV and REM. All others are unsigned.
  - Load the counter with XLEN and go to BUSY.
  - Fast path: for DIV/DIVU/REM/REMU with op2 = 0, or DIV/REM with op1 = most-negative and op2 = −1, go directly to DONE.
- **BUSY:**
  - Each cycle performs one iteration and decrements the counter.
  - Multiply: when the multiplier LSB is 1, add the multiplicand to the high half of a 2·XLEN accumulator, then shift right one.
  - Divide: shift the {remainder, quotient} pair left, trial-subtract the divisor, and keep the result if it is non-negative, setting the quotient bit.
  - The counter reaching 1 triggers sign correction and goes to DONE.
- **Sign correction:**
  - The product is negated when the operand signs differ (MULHSU treats op2 as positive).
  - The quotient is negated when the signs differ.
  - The remainder takes the sign of the dividend.
- **Result selection:**
  - MUL gives the low product half.
  - MULH, MULHSU and MULHU give the high half.
  - DIV/DIVU give the quotient; REM/REMU give the remainder.
- **Special results:**
  - Divide by zero: quotient all-ones, remainder = op1.
  - Overflow: quotient = op1 (most-negative), remainder = 0.
- **DONE:** done = 1 and result is valid. Go to IDLE unconditionally; op_valid is never accepted in DONE.
- **Flush:** flush in any state gives IDLE on the next edge. done stays 0 and result is unchanged. Flush with op_valid in IDLE causes no accept.
- **Reset:** asynchronous active-low reset gives state IDLE, done 0, result 0, counter 0 and busy 0 immediately. This applies at any point in an operation; no completion follows.
- All arithmetic is modulo 2^XLEN (2^(2·XLEN) for the accumulator). The divider uses an (XLEN+1)-bit subtractor.

## Timing
- Take op_valid as high in cycle 0 with the unit in IDLE.
- Normal operation: BUSY spans cycles 1..XLEN, and done/result are valid in cycle XLEN+1 (33 cycles for XLEN=32).
- Fast path: done in cycle 1.
- stall_req is high in cycles 0..XLEN and low in the done cycle, so the pipeline advances at the end of the done cycle.
- Back-to-back M instructions: the next instruction reaches EX in cycle XLEN+2. The unit is then IDLE and accepts it there, so there is a 1-cycle IDLE gap with stall_req high.
- busy is high from cycle 1 through the done cycle.
- After reset release, the first accept occurs on the first edge where op_valid = 1.
- Changes to op1, op2 or funct3 after the accept cycle are ignored.

## Test plan
- XLEN=32, MUL op1=7, op2=0xFFFFFFFD (−3) → done in cycle 33, result 0xFFFFFFEB, stall_req high cycles 0–32.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Signed and unsigned divides:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - Each completes in cycle 33.
- Special cases, each with done in cycle 1:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Flush in cycle 10 of a DIVU → IDLE in cycle 11, done never pulses, result unchanged. A new MUL 3×4 accepted in cycle 11 gives 12 in cycle 44.
- rst low in cycle 5 of a MUL → done = 0, result = 0, busy = 0 asynchronously. After release, a back-to-back pair MUL 2×3 then DIVU 9/2 gives 6 in cycle 33 and 4 in cycle 67.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one iteration per cycle, with a single-cycle path for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            op_valid,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic [1:0]      fsm_state
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES = '1;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    // Handshake: an operation is accepted on the edge where op_valid=1, flush=0 and
    // state is IDLE; done pulses one cycle with result, and stall_req drops in that cycle.
    state_t            state, state_n;
    logic [2:0]        fn, fn_n;
    logic              neg_a, neg_a_n, neg_b, neg_b_n;
    logic [XLEN-1:0]   opnd, opnd_n;
    logic [2*XLEN-1:0] acc, acc_n, acc_it, prod;
    logic [CW-1:0]     cnt, cnt_n;
    logic [XLEN-1:0]   result_n, quo, rem, final_res, mag1, mag2, special_res;
    logic              done_n, sgn1, sgn2, div_zero, ovf;
    logic [XLEN:0]     mul_sum, rem_ext, diff;

    // Operand preparation and one datapath iteration.
    always_comb begin
        sgn1 = op1[XLEN-1] & ~(funct3 == 3'd3 || funct3 == 3'd5 || funct3 == 3'd7);
        sgn2 = op2[XLEN-1] & ~(funct3 == 3'd2 || funct3 == 3'd3 || funct3 == 3'd5 || funct3 == 3'd7);
        mag1 = sgn1 ? -op1 : op1;
        mag2 = sgn2 ? -op2 : op2;
        div_zero = funct3[2] && (op2 == '0);
        ovf = funct3[2] && !funct3[0] && (op1 == MIN) && (op2 == ONES);
        if (div_zero) special_res = funct3[1] ? op1 : ONES;
        else          special_res = funct3[1] ? '0 : op1;

        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_ext = acc[2*XLEN-1:XLEN-1];
        diff    = rem_ext - {1'b0, opnd};
        if (fn[2]) begin
            // A negative trial difference restores the shifted remainder.
            if (diff[XLEN]) acc_it = {acc[2*XLEN-2:0], 1'b0};
            else            acc_it = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_it = {mul_sum, acc[XLEN-1:1]};
        end

        prod = (neg_a ^ neg_b) ? -acc_it : acc_it;
        quo  = (neg_a ^ neg_b) ? -acc_it[XLEN-1:0] : acc_it[XLEN-1:0];
        rem  = neg_a ? -acc_it[2*XLEN-1:XLEN] : acc_it[2*XLEN-1:XLEN];
        case (fn)
            3'd0:                final_res = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    final_res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:          final_res = quo;
            default:             final_res = rem;
        endcase
    end

    always_comb begin
        state_n  = state;
        fn_n     = fn;
        neg_a_n  = neg_a;
        neg_b_n  = neg_b;
        opnd_n   = opnd;
        acc_n    = acc;
        cnt_n    = cnt;
        result_n = result;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    fn_n    = funct3;
                    neg_a_n = sgn1;
                    neg_b_n = sgn2;
                    if (div_zero || ovf) begin
                        result_n = special_res;
                        done_n   = 1'b1;
                        state_n  = DONE;
                    end else begin
                        // Multiplier/dividend sits in the low half; the other operand is held aside.
                        opnd_n  = funct3[2] ? mag2 : mag1;
                        acc_n   = {{XLEN{1'b0}}, funct3[2] ? mag1 : mag2};
                        cnt_n   = CW'(XLEN);
                        state_n = BUSY;
                    end
                end
            end
            BUSY: begin
                acc_n = acc_it;
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    result_n = final_res;
                    done_n   = 1'b1;
                    state_n  = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (flush) begin
            state_n  = IDLE;
            done_n   = 1'b0;
            result_n = result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            fn     <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            fn     <= fn_n;
            neg_a  <= neg_a_n;
            neg_b  <= neg_b_n;
            opnd   <= opnd_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            result <= result_n;
            done   <= done_n;
        end
    end

    assign stall_req = op_valid & ~done;
    assign busy      = (state != IDLE);
    assign fsm_state = state;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded bench for muldiv_unit: directed RV32M cases, flush and reset
// scenarios, then randomized operations checked against an arithmetic model.
module tb_muldiv_unit;
    localparam int XLEN = 32;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        stall_req, done, busy;
    logic [31:0] result;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    logic [XLEN-1:0] exp_q[$];
    int cyc_q[$];
    logic [31:0] last_exp = '0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .funct3(funct3),
        .op1(op1), .op2(op2), .stall_req(stall_req), .done(done), .result(result),
        .busy(busy), .fsm_state(fsm_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    // reference model: plain wide arithmetic on the RISC-V M rules
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return '1;
                else if (a == MIN && b == '1) return MIN;
                else return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 0) return '1;
                else return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                else if (a == MIN && b == '1) return '0;
                else return 32'(ia % ib);
            end
            default: begin
                if (b == 0) return a;
                else return a % b;
            end
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == MIN && b == '1));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return MIN;
            4: return 32'($urandom_range(0, 100));
            default: return $urandom;
        endcase
    endfunction

    // scoreboard monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        logic [31:0] e;
        int ec;
        if (rst && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                ec = cyc_q.pop_front();
                check("result", result, e);
                check("latency", 32'(cyc), 32'(ec));
                last_exp = e;
            end
        end
    end

    // driver: called just after a negedge; leaves op_valid high through the done cycle
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv);
        int c0;
        bit seen, stall_ok;
        c0 = busy ? cyc + 1 : cyc;
        funct3 = f; op1 = a; op2 = b; op_valid = 1'b1;
        exp_q.push_back(expv);
        cyc_q.push_back(c0 + (is_fast(f, a, b) ? 1 : XLEN + 1));
        seen = 0;
        stall_ok = 1;
        for (int i = 0; i < XLEN + 6 && !seen; i++) begin
            #1;
            if (!done && !stall_req) stall_ok = 0;
            @(negedge clk);
            if (cyc > c0) begin
                op1 = $urandom; op2 = $urandom; funct3 = 3'($urandom_range(0, 7));
            end
            if (done) seen = 1;
        end
        #1;
        check("done_seen", {31'd0, seen}, 32'd1);
        check("stall_while_busy", {31'd0, stall_ok}, 32'd1);
        check("stall_in_done", {31'd0, stall_req}, 32'd0);
    endtask

    task automatic idle();
        op_valid = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] f;
        logic [31:0] a, b;
        int c0;

        repeat (3) @(negedge clk);
        #1;
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB); idle();
        do_op(3'd1, MIN, MIN, 32'h4000_0000);              idle();
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF); idle();
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);  idle();
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);  idle();
        do_op(3'd5, 32'd100, 32'd7, 32'd14);
        do_op(3'd7, 32'd100, 32'd7, 32'd2);                idle();
        do_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);          idle();
        do_op(3'd7, 32'd5, 32'd0, 32'd5);
        do_op(3'd4, MIN, 32'hFFFF_FFFF, MIN);              idle();
        do_op(3'd6, MIN, 32'hFFFF_FFFF, 32'd0);            idle();

        // flush of a DIVU in cycle 10, then MUL 3x4 accepted in cycle 11
        c0 = cyc;
        funct3 = 3'd5; op1 = 32'd1000; op2 = 32'd3; op_valid = 1'b1;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_cycle", 32'(cyc - c0), 32'd11);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_result", result, last_exp);
        do_op(3'd0, 32'd3, 32'd4, 32'd12); idle();

        // asynchronous reset in cycle 5 of a MUL
        funct3 = 3'd0; op1 = 32'd5; op2 = 32'd6; op_valid = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        last_exp = '0;
        #1;
        do_op(3'd0, 32'd2, 32'd3, 32'd6);
        do_op(3'd5, 32'd9, 32'd2, 32'd4);
        idle();

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            do_op(f, a, b, model(f, a, b));
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();
        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
